// File: rtl/uart_port_responder_if.sv
// Strobe/status bus between the CPU MemoryController and the UART responder.
// The master drives the strobes and the transmit byte; the slave returns
// the receive buffer and the three status bits.
interface uart_port_responder_if;
  logic       rdn;
  logic       wrn;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_ready;
  logic       tbre;
  logic       tsre;

  modport master (
    output rdn,
    output wrn,
    output data_in,
    input  data_out,
    input  data_ready,
    input  tbre,
    input  tsre
  );

  modport slave (
    input  rdn,
    input  wrn,
    input  data_in,
    output data_out,
    output data_ready,
    output tbre,
    output tsre
  );
endinterface

// File: rtl/uart_port_responder.sv
// FPGA-side stand-in for the external UART chip. It answers the
// MemoryController rdn/wrn handshake with a one-byte transmit holding
// register, a transmit shifter, a receiver and a one-byte receive buffer.
module uart_port_responder #(
  parameter int DIVISOR     = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_port_responder_if.slave  bus,
  input  logic                  rxd,
  output logic                  txd,
  input  logic                  err_clr,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DIVISOR + 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIVISOR);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DIVISOR / 2);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Synchronizer chains; each input idles high, so they reset to all ones
  logic [SYNC_STAGES-1:0] rdn_sync_q, rdn_sync_d;
  logic [SYNC_STAGES-1:0] wrn_sync_q, wrn_sync_d;
  logic [SYNC_STAGES-1:0] rxd_sync_q, rxd_sync_d;
  logic rdn_prev_q, rdn_prev_d;
  logic wrn_prev_q, wrn_prev_d;
  logic rxd_prev_q, rxd_prev_d;
  logic rd_evt, wr_evt, rx_fall, rxd_s;

  // Transmit path state
  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       thr_q, thr_d;
  logic             tbre_q, tbre_d;
  logic             tsre_q, tsre_d;
  logic             txd_q, txd_d;
  logic             tx_load;

  // Receive path state
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rbr_q, rbr_d;
  logic             data_ready_q, data_ready_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_deliver, rx_bad_stop;

  // Shift each asynchronous input into its chain and find edges on the last stage
  always_comb begin
    rdn_sync_d = {rdn_sync_q[SYNC_STAGES-2:0], bus.rdn};
    wrn_sync_d = {wrn_sync_q[SYNC_STAGES-2:0], bus.wrn};
    rxd_sync_d = {rxd_sync_q[SYNC_STAGES-2:0], rxd};
    rdn_prev_d = rdn_sync_q[SYNC_STAGES-1];
    wrn_prev_d = wrn_sync_q[SYNC_STAGES-1];
    rxd_prev_d = rxd_sync_q[SYNC_STAGES-1];
    rxd_s      = rxd_sync_q[SYNC_STAGES-1];
    rd_evt     = rdn_sync_q[SYNC_STAGES-1] & ~rdn_prev_q;
    wr_evt     = wrn_sync_q[SYNC_STAGES-1] & ~wrn_prev_q;
    rx_fall    = ~rxd_sync_q[SYNC_STAGES-1] & rxd_prev_q;
  end

  // Synchronizer and edge-history registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdn_sync_q <= '1;
      wrn_sync_q <= '1;
      rxd_sync_q <= '1;
      rdn_prev_q <= 1'b1;
      wrn_prev_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rdn_sync_q <= rdn_sync_d;
      wrn_sync_q <= wrn_sync_d;
      rxd_sync_q <= rxd_sync_d;
      rdn_prev_q <= rdn_prev_d;
      wrn_prev_q <= wrn_prev_d;
      rxd_prev_q <= rxd_prev_d;
    end
  end

  // Transmit FSM; a write landing in the shifter-load cycle still fills THR
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    thr_d      = thr_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tbre_q) begin
          tx_load    = 1'b1;
          tsre_d     = 1'b0;
          tx_state_d = TX_START;
          tx_cnt_d   = DIV_CNT;
        end
      end
      TX_START: begin
        if (tx_cnt_q == ONE_CNT) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = DIV_CNT;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q - ONE_CNT;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == ONE_CNT) begin
          tx_cnt_d   = DIV_CNT;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - ONE_CNT;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == ONE_CNT) begin
          if (!tbre_q) begin
            tx_load    = 1'b1;
            tx_state_d = TX_START;
            tx_cnt_d   = DIV_CNT;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - ONE_CNT;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_shift_d = thr_q;
      tbre_d     = 1'b1;
    end
    if (wr_evt && (tbre_q || tx_load)) begin
      thr_d  = bus.data_in;
      tbre_d = 1'b0;
    end
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // Transmit registers; txd is registered so the line never glitches
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      thr_q      <= 8'd0;
      tbre_q     <= 1'b1;
      tsre_q     <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      thr_q      <= thr_d;
      tbre_q     <= tbre_d;
      tsre_q     <= tsre_d;
      txd_q      <= txd_d;
    end
  end

  // Receive FSM plus buffer/flag update; delivery beats a same-cycle read
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_deliver  = 1'b0;
    rx_bad_stop = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_CNT;
        end
      end
      RX_START: begin
        if (rx_cnt_q == ONE_CNT) begin
          if (!rxd_s) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = DIV_CNT;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - ONE_CNT;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == ONE_CNT) begin
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          rx_cnt_d   = DIV_CNT;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - ONE_CNT;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == ONE_CNT) begin
          rx_state_d  = RX_IDLE;
          rx_deliver  = rxd_s;
          rx_bad_stop = ~rxd_s;
        end else begin
          rx_cnt_d = rx_cnt_q - ONE_CNT;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    rbr_d        = rbr_q;
    data_ready_d = data_ready_q;
    overrun_d    = err_clr ? 1'b0 : overrun_q;
    frame_err_d  = err_clr ? 1'b0 : frame_err_q;
    if (rd_evt) begin
      data_ready_d = 1'b0;
    end
    if (rx_deliver) begin
      rbr_d        = rx_shift_q;
      data_ready_d = 1'b1;
      if (data_ready_q && !rd_evt) begin
        overrun_d = 1'b1;
      end
    end
    if (rx_bad_stop) begin
      frame_err_d = 1'b1;
    end
  end

  // Receive registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      rbr_q        <= 8'd0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rbr_q        <= rbr_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign txd            = txd_q;
  assign bus.tbre       = tbre_q;
  assign bus.tsre       = tsre_q;
  assign bus.data_out   = rbr_q;
  assign bus.data_ready = data_ready_q;
  assign overrun        = overrun_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_uart_port_responder.sv
// Directed bench for uart_port_responder at DIVISOR=4, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_uart_port_responder;

  logic CLK = 1'b0;
  logic RST;
  logic rxd;
  logic txd;
  logic err_clr;
  logic overrun;
  logic frame_err;
  int   checks_total  = 0;
  int   checks_passed = 0;

  uart_port_responder_if bus_if ();

  uart_port_responder #(.DIVISOR(4), .SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus_if.slave),
    .rxd       (rxd),
    .txd       (txd),
    .err_clr   (err_clr),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  // 10-unit clock
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hold wrn low for 3 cycles with data stable, then release
  task automatic applyStimulus(input logic [7:0] b);
    bus_if.data_in = b;
    bus_if.wrn = 1'b0;
    tick(3);
    bus_if.wrn = 1'b1;
  endtask

  task automatic pulseRead();
    bus_if.rdn = 1'b0;
    tick(3);
    bus_if.rdn = 1'b1;
  endtask

  task automatic sendRxFrame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(4);
    end
    rxd = stop_bit;
    tick(4);
    rxd = 1'b1;
  endtask

  function automatic logic frameBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Check txd every cycle across nframes back-to-back 40-cycle frames
  task automatic checkTxFrames(input logic [7:0] b0, input logic [7:0] b1, input int nframes);
    logic [7:0] b;
    for (int i = 0; i < nframes * 40; i++) begin
      b = (i < 40) ? b0 : b1;
      checkOutput($sformatf("txd_cycle%0d", i), {7'd0, txd}, {7'd0, frameBit(b, (i % 40) / 4)});
      tick(1);
    end
  endtask

  initial begin
    logic low_seen;
    RST = 1'b1;
    rxd = 1'b1;
    err_clr = 1'b0;
    bus_if.rdn = 1'b1;
    bus_if.wrn = 1'b1;
    bus_if.data_in = 8'd0;
    tick(3);
    checkOutput("rst_txd", {7'd0, txd}, 8'd1);
    checkOutput("rst_tbre", {7'd0, bus_if.tbre}, 8'd1);
    checkOutput("rst_tsre", {7'd0, bus_if.tsre}, 8'd1);
    checkOutput("rst_data_ready", {7'd0, bus_if.data_ready}, 8'd0);
    checkOutput("rst_data_out", bus_if.data_out, 8'h00);
    checkOutput("rst_flags", {6'd0, overrun, frame_err}, 8'd0);
    RST = 1'b0;
    tick(3);

    $display("[TB] single TX 0x55");
    applyStimulus(8'h55);
    tick(3);
    checkOutput("tx1_tbre_taken", {7'd0, bus_if.tbre}, 8'd0);
    checkOutput("tx1_tsre_before", {7'd0, bus_if.tsre}, 8'd1);
    tick(1);
    checkOutput("tx1_tbre_freed", {7'd0, bus_if.tbre}, 8'd1);
    checkOutput("tx1_tsre_busy", {7'd0, bus_if.tsre}, 8'd0);
    checkTxFrames(8'h55, 8'h00, 1);
    checkOutput("tx1_tsre_done", {7'd0, bus_if.tsre}, 8'd1);
    checkOutput("tx1_txd_idle", {7'd0, txd}, 8'd1);
    tick(5);

    $display("[TB] back-to-back TX 0xA3, 0x0F, ignored 0x77");
    applyStimulus(8'hA3);
    tick(4);
    fork
      begin
        applyStimulus(8'h0F);
        tick(4);
        checkOutput("b2b_tbre_full", {7'd0, bus_if.tbre}, 8'd0);
        applyStimulus(8'h77);
      end
      checkTxFrames(8'hA3, 8'h0F, 2);
    join
    checkOutput("b2b_tsre_done", {7'd0, bus_if.tsre}, 8'd1);
    tick(12);
    checkOutput("b2b_no_third_txd", {7'd0, txd}, 8'd1);
    checkOutput("b2b_no_third_tbre", {7'd0, bus_if.tbre}, 8'd1);
    checkOutput("b2b_no_third_tsre", {7'd0, bus_if.tsre}, 8'd1);

    $display("[TB] RX 0xC6 with read handshake");
    sendRxFrame(8'hC6, 1'b1);
    tick(2);
    checkOutput("rx_ready", {7'd0, bus_if.data_ready}, 8'd1);
    checkOutput("rx_data", bus_if.data_out, 8'hC6);
    checkOutput("rx_flags_clean", {6'd0, overrun, frame_err}, 8'd0);
    pulseRead();
    tick(1);
    checkOutput("rd_not_yet", {7'd0, bus_if.data_ready}, 8'd1);
    tick(3);
    checkOutput("rd_cleared", {7'd0, bus_if.data_ready}, 8'd0);
    checkOutput("rd_data_held", bus_if.data_out, 8'hC6);

    $display("[TB] RX overrun and framing error");
    sendRxFrame(8'h11, 1'b1);
    tick(2);
    checkOutput("ovr_first_data", bus_if.data_out, 8'h11);
    checkOutput("ovr_first_clean", {7'd0, overrun}, 8'd0);
    sendRxFrame(8'h22, 1'b1);
    tick(2);
    checkOutput("ovr_set", {7'd0, overrun}, 8'd1);
    checkOutput("ovr_data", bus_if.data_out, 8'h22);
    sendRxFrame(8'h5A, 1'b0);
    tick(2);
    checkOutput("ferr_set", {7'd0, frame_err}, 8'd1);
    checkOutput("ferr_data_kept", bus_if.data_out, 8'h22);
    checkOutput("ferr_ready_kept", {7'd0, bus_if.data_ready}, 8'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checkOutput("errclr_flags", {6'd0, overrun, frame_err}, 8'd0);
    pulseRead();
    tick(4);
    checkOutput("rd2_cleared", {7'd0, bus_if.data_ready}, 8'd0);

    $display("[TB] RX glitch");
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(20);
    checkOutput("glitch_ready", {7'd0, bus_if.data_ready}, 8'd0);
    checkOutput("glitch_flags", {6'd0, overrun, frame_err}, 8'd0);
    checkOutput("glitch_data", bus_if.data_out, 8'h22);

    $display("[TB] read release colliding with delivery");
    sendRxFrame(8'h3C, 1'b1);
    tick(2);
    checkOutput("col_pre_ready", {7'd0, bus_if.data_ready}, 8'd1);
    checkOutput("col_pre_data", bus_if.data_out, 8'h3C);
    tick(4);
    fork
      sendRxFrame(8'h99, 1'b1);
      begin
        tick(35);
        bus_if.rdn = 1'b0;
        tick(3);
        bus_if.rdn = 1'b1;
      end
    join
    tick(2);
    checkOutput("col_ready", {7'd0, bus_if.data_ready}, 8'd1);
    checkOutput("col_overrun", {7'd0, overrun}, 8'd0);
    checkOutput("col_data", bus_if.data_out, 8'h99);
    tick(4);
    checkOutput("col_ready_later", {7'd0, bus_if.data_ready}, 8'd1);

    $display("[TB] reset mid TX frame");
    applyStimulus(8'h81);
    tick(14);
    checkOutput("midrst_pre_txd", {7'd0, txd}, 8'd0);
    #3;
    RST = 1'b1;
    #1;
    checkOutput("midrst_txd", {7'd0, txd}, 8'd1);
    checkOutput("midrst_tbre", {7'd0, bus_if.tbre}, 8'd1);
    checkOutput("midrst_tsre", {7'd0, bus_if.tsre}, 8'd1);
    checkOutput("midrst_ready", {7'd0, bus_if.data_ready}, 8'd0);
    checkOutput("midrst_data_out", bus_if.data_out, 8'h00);
    tick(1);
    RST = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1) low_seen = 1'b1;
      tick(1);
    end
    checkOutput("midrst_no_bits", {7'd0, low_seen}, 8'd0);
    checkOutput("midrst_tbre_after", {7'd0, bus_if.tbre}, 8'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
